booth_seq_multiplier: RTL and testbench
=======================================

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be even and in range 8..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands and mode present on a, b, is_signed.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 out_valid  output  1  product holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 product  output  2*WIDTH  exact product of a and b.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b and is_signed are latched and the state moves IDLE->CALC.
REQ-015 After acceptance, changes on a, b and is_signed SHALL have no effect on the operation in flight.
REQ-016 Latched operands SHALL be extended to WIDTH+2 bits (sign-extended if is_signed, zero-extended otherwise) and recoded into WIDTH/2+1 radix-4 Booth digits, each in {-2,-1,0,+1,+2}.
REQ-017 CALC SHALL process exactly one Booth digit per cycle, from least significant to most significant, accumulating into a 2*WIDTH+2-bit partial product with an arithmetic shift right by 2 per digit.
REQ-018 An iteration counter of ceil(log2(WIDTH/2+2)) bits SHALL count CALC cycles; after WIDTH/2+1 CALC edges the state SHALL move CALC->DONE.
REQ-019 Latency SHALL be fixed: out_valid rises exactly WIDTH/2+1 rising edges after the accepting edge (17 for WIDTH=32), independent of operand values, including zero operands.
REQ-020 product SHALL equal a*b mod 2^(2*WIDTH), interpreted per is_signed; the result is always exact for both modes, including signed (-2^(WIDTH-1))^2 and unsigned (2^WIDTH-1)^2.
REQ-021 In DONE, product and out_valid SHALL hold stable while out_ready=0.
REQ-022 On an edge in DONE with out_ready=1, the state SHALL move to IDLE and out_valid SHALL fall; product SHALL retain its value until the next result is written.
REQ-023 in_valid while not in IDLE SHALL be ignored (no queueing); the minimum issue interval is WIDTH/2+3 cycles.
REQ-024 out_ready while not in DONE SHALL be ignored.

Reset
REQ-025 reset=1 on a rising edge SHALL force IDLE and clear product, the accumulator, the latched operands and the counter to 0.
REQ-026 After reset, in_ready=1 and out_valid=0.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation with no result emitted; reset has priority over all handshakes.

Structure
REQ-028 A shared package mult_pkg SHALL hold the state enum typedef (IDLE, CALC, DONE) and the Booth digit typedef (3-bit signed, range -2..+2).
REQ-029 Sub-module booth_radix4_encoder SHALL be combinational and map a 3-bit overlapping multiplier slice to one Booth digit.
REQ-030 The digit-to-addend selection (0, ±A, ±2A) and the accumulator SHALL live in the top module; no combinational path SHALL exist from a or b to product.

Verification
REQ-031 WIDTH=32, is_signed=1, a=-7, b=6 → after 17 edges: out_valid=1, product=64'hFFFF_FFFF_FFFF_FFD6 (-42).
REQ-032 WIDTH=32, is_signed=0, a=b=32'hFFFF_FFFF → product=64'hFFFF_FFFE_0000_0001; same operands with is_signed=1 → product=1.
REQ-033 WIDTH=8, is_signed=1, a=b=8'h80 → product=16'h4000; latency 5 edges.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b → product is stable, in_ready=0 and no second acceptance occurs.
REQ-035 Assert reset mid-CALC (cycle 8, WIDTH=32) → next cycle: IDLE, product=0, out_valid=0; a new operation completes correctly.
REQ-036 Run 1000 random back-to-back operations (both modes, WIDTH 8/32/64) with random out_ready → every product matches the reference model, in order, with fixed latency.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types for the sequential radix-4 Booth multiplier.
//   state_t       : controller states (IDLE, CALC, DONE)
//   booth_digit_t : one recoded radix-4 Booth digit, signed, range -2..+2
//   D_*           : named digit values used by the encoder and the addend mux
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t D_ZERO = 3'sb000;
  localparam booth_digit_t D_P1   = 3'sb001;
  localparam booth_digit_t D_P2   = 3'sb010;
  localparam booth_digit_t D_M2   = 3'sb110;
  localparam booth_digit_t D_M1   = 3'sb111;

endpackage

// File: rtl/booth_radix4_encoder.sv
// -----------------------------------------------------------------------------
// booth_radix4_encoder
// Combinational radix-4 Booth recoder. Maps one overlapping multiplier slice
// {b[2i+1], b[2i], b[2i-1]} to a digit in {-2,-1,0,+1,+2}.
// Ports:
//   slice_i : 3-bit overlapping multiplier slice
//   digit_o : recoded Booth digit
// -----------------------------------------------------------------------------
module booth_radix4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]   slice_i,
  output booth_digit_t digit_o
);

  always_comb begin
    digit_o = D_ZERO;
    unique case (slice_i)
      3'b001, 3'b010: digit_o = D_P1;
      3'b011:         digit_o = D_P2;
      3'b100:         digit_o = D_M2;
      3'b101, 3'b110: digit_o = D_M1;
      default:        digit_o = D_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// booth_seq_multiplier
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned.
// Fixed latency: out_valid rises WIDTH/2+1 edges after the accepting edge.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a, b, is_signed      : multiplicand, multiplier, operand interpretation
//   out_valid / out_ready: result handshake (valid only while done)
//   product              : registered 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NDIG  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(WIDTH / 2 + 2);
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t                    state_q, state_d;
  logic signed [WIDTH+1:0]   a_q, a_d;
  // Extended multiplier with an implicit 0 appended below the LSB; it shifts
  // right by two each CALC cycle so the current slice is always b_q[2:0].
  logic        [WIDTH+2:0]   b_q, b_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [2*WIDTH-1:0] prod_q, prod_d;

  booth_digit_t              digit;
  logic signed [ACC_W-1:0]   a_wide;
  logic signed [ACC_W-1:0]   addend;

  booth_radix4_encoder u_enc (
    .slice_i (b_q[2:0]),
    .digit_o (digit)
  );

  // Addends enter at weight 2^WIDTH and the accumulator is pre-shifted by 2
  // each step, so after WIDTH/2+1 digits the accumulator equals A*B exactly
  // with no bits lost off the bottom.
  always_comb begin
    a_wide = {{WIDTH{a_q[WIDTH+1]}}, a_q};
    unique case (digit)
      D_P1:    addend = a_wide <<< WIDTH;
      D_P2:    addend = a_wide <<< (WIDTH + 1);
      D_M1:    addend = -(a_wide <<< WIDTH);
      D_M2:    addend = -(a_wide <<< (WIDTH + 1));
      default: addend = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
          b_d     = {(is_signed ? {2{b[WIDTH-1]}} : 2'b00), b, 1'b0};
          cnt_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = (acc_q >>> 2) + addend;
        b_d   = {2'b00, b_q[WIDTH+2:2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_d  = acc_d[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_multiplier
// Three multiplier instances (WIDTH 8, 32, 64) against a transaction-level
// model: product = a*b mod 2^(2W) from plain 128-bit arithmetic, out_valid a
// fixed W/2+1 edges after acceptance, held until consumed.
// -----------------------------------------------------------------------------
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [3];
  logic        sg   [3];
  logic        ordy [3];
  logic [63:0] av   [3];
  logic [63:0] bv   [3];
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [15:0] p8;
  wire  [63:0] p32;
  wire  [127:0] p64;
  logic [127:0] prod [3];

  always_comb begin
    prod[0] = {112'd0, p8};
    prod[1] = {64'd0, p32};
    prod[2] = p64;
  end

  booth_seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .is_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .product(p8));

  booth_seq_multiplier #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][31:0]), .b(bv[1][31:0]), .is_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .product(p32));

  booth_seq_multiplier #(.WIDTH(64)) u_w64 (
    .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .is_signed(sg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .product(p64));

  int n_vec;
  int n_cmp;
  int n_fail;
  logic chk_on;

  function automatic int wid(int k);
    return (k == 0) ? 8 : ((k == 1) ? 32 : 64);
  endfunction

  function automatic int lat_of(int k);
    return wid(k) / 2 + 1;
  endfunction

  // Reference product: extend both operands to 128 bits per mode, multiply,
  // keep the low 2W bits.
  function automatic logic [127:0] ref_mul(int w, logic [63:0] x, logic [63:0] y, logic s);
    logic [127:0] m;
    logic [127:0] xx;
    logic [127:0] yy;
    logic [127:0] p;
    m  = (128'd1 << w) - 128'd1;
    xx = {64'd0, x} & m;
    yy = {64'd0, y} & m;
    if (s && xx[w-1]) xx = xx | ~m;
    if (s && yy[w-1]) yy = yy | ~m;
    p = xx * yy;
    if (w < 64) p = p & ((128'd1 << (2 * w)) - 128'd1);
    return p;
  endfunction

  function automatic logic [63:0] pick(int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1 << (w - 1);
      3:       return 64'd1;
      4:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(string nm, int k, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s w=%0d t=%0t got=%h want=%h", nm, wid(k), $time, got, exp);
    end
  endtask

  // Transaction model: idle -> busy for W/2+1 edges -> done until consumed.
  int           m_st   [3];
  int           m_cnt  [3];
  logic [127:0] m_pend [3];
  logic [127:0] m_prod [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_st[k]   <= 0;
        m_cnt[k]  <= 0;
        m_prod[k] <= '0;
      end else begin
        case (m_st[k])
          0: if (iv[k]) begin
               m_st[k]   <= 1;
               m_cnt[k]  <= 1;
               m_pend[k] <= ref_mul(wid(k), av[k], bv[k], sg[k]);
             end
          1: if (m_cnt[k] == lat_of(k)) begin
               m_st[k]   <= 2;
               m_prod[k] <= m_pend[k];
             end else begin
               m_cnt[k] <= m_cnt[k] + 1;
             end
          2: if (ordy[k]) m_st[k] <= 0;
          default: m_st[k] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check("in_ready",  k, 128'(ir[k]), 128'(m_st[k] == 0));
        check("out_valid", k, 128'(ov[k]), 128'(m_st[k] == 2));
        check("product",   k, prod[k], m_prod[k]);
      end
    end
  end

  task automatic issue(int k, logic [63:0] x, logic [63:0] y, logic s);
    iv[k] = 1'b1;
    av[k] = x;
    bv[k] = y;
    sg[k] = s;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0;
    n_vec++;
  endtask

  task automatic wait_result(int k, output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[k]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume(int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask

  task automatic rand_run(int k, int nops);
    int done_ops;
    int guard;
    done_ops = 0;
    guard    = 0;
    while (done_ops < nops && guard < 40000) begin
      guard++;
      ordy[k] = ($urandom_range(0, 3) != 0);
      iv[k]   = ($urandom_range(0, 4) != 0);
      av[k]   = pick(wid(k));
      bv[k]   = pick(wid(k));
      sg[k]   = 1'($urandom_range(0, 1));
      if (iv[k] && m_st[k] == 0) begin
        done_ops++;
        n_vec++;
      end
      @(negedge clk);
    end
    check("rand_ops_issued", k, 128'(done_ops), 128'(nops));
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    guard   = 0;
    while (m_st[k] != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_in_ready", k, 128'(ir[k]), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_vec = 0; n_cmp = 0; n_fail = 0; chk_on = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; sg[k] = 1'b0; ordy[k] = 1'b0; av[k] = '0; bv[k] = '0;
    end

    // Hand-computed values that pin the reference model.
    check("model_m7x6",     1, ref_mul(32, 64'hFFFF_FFF9, 64'd6, 1'b1), 128'hFFFF_FFFF_FFFF_FFD6);
    check("model_u32max",   1, ref_mul(32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0), 128'hFFFF_FFFE_0000_0001);
    check("model_s32m1",    1, ref_mul(32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1), 128'd1);
    check("model_s8min",    0, ref_mul(8, 64'h80, 64'h80, 1'b1), 128'h4000);
    check("model_u64max",   2, ref_mul(64, '1, '1, 1'b0), 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready",  k, 128'(ir[k]), 128'd1);
      check("rst_out_valid", k, 128'(ov[k]), 128'd0);
      check("rst_product",   k, prod[k], 128'd0);
    end

    issue(1, 64'hFFFF_FFF9, 64'd6, 1'b1);
    wait_result(1, lat);
    check("lat_m7x6", 1, 128'(lat), 128'd17);
    check("prod_m7x6", 1, prod[1], 128'hFFFF_FFFF_FFFF_FFD6);
    consume(1);

    issue(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    wait_result(1, lat);
    check("prod_u32max", 1, prod[1], 128'hFFFF_FFFE_0000_0001);
    consume(1);

    issue(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
    wait_result(1, lat);
    check("prod_s32m1", 1, prod[1], 128'd1);

    for (int i = 0; i < 10; i++) begin
      iv[1] = 1'($urandom_range(0, 1));
      av[1] = {$urandom, $urandom};
      bv[1] = {$urandom, $urandom};
      @(negedge clk);
      check("hold_product",   1, prod[1], 128'd1);
      check("hold_in_ready",  1, 128'(ir[1]), 128'd0);
      check("hold_out_valid", 1, 128'(ov[1]), 128'd1);
    end
    iv[1] = 1'b0;
    consume(1);
    check("post_out_valid", 1, 128'(ov[1]), 128'd0);
    check("post_retain",    1, prod[1], 128'd1);

    issue(0, 64'h80, 64'h80, 1'b1);
    wait_result(0, lat);
    check("lat_s8min",  0, 128'(lat), 128'd5);
    check("prod_s8min", 0, prod[0], 128'h4000);
    consume(0);

    issue(2, '1, '1, 1'b0);
    wait_result(2, lat);
    check("lat_u64max",  2, 128'(lat), 128'd33);
    check("prod_u64max", 2, prod[2], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    consume(2);

    issue(1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 1, 128'(ov[1]), 128'd0);
    check("abort_product",   1, prod[1], 128'd0);
    check("abort_in_ready",  1, 128'(ir[1]), 128'd1);

    issue(1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1);
    wait_result(1, lat);
    check("lat_after_abort",  1, 128'(lat), 128'd17);
    check("prod_after_abort", 1, prod[1], ref_mul(32, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1));
    consume(1);

    fork
      rand_run(0, 334);
      rand_run(1, 333);
      rand_run(2, 333);
    join

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
